// File: rtl/ppu_vram_arb_if.sv
// PPU video-memory bus bundle: three requesters, shared read return,
// external VRAM pins and the pixel-path palette lookup port.
interface ppu_vram_arb_if;
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;
    localparam int unsigned IW = 5;

    logic          bg_req;
    logic [AW-1:0] bg_a;
    logic          bg_gnt;
    logic          bg_vld;

    logic          spr_req;
    logic [AW-1:0] spr_a;
    logic          spr_gnt;
    logic          spr_vld;

    logic          ri_req;
    logic          ri_wr;
    logic [AW-1:0] ri_a;
    logic [DW-1:0] ri_d;
    logic          ri_gnt;
    logic          ri_vld;

    logic [DW-1:0] rd_d;

    logic [AW-1:0] vram_a;
    logic [DW-1:0] vram_d;
    logic          vram_wr;
    logic [DW-1:0] vram_q;

    logic [IW-1:0] pal_idx;
    logic [PW-1:0] pal_d;

    modport master (
        output bg_req, bg_a, spr_req, spr_a,
        output ri_req, ri_wr, ri_a, ri_d,
        output vram_q, pal_idx,
        input  bg_gnt, bg_vld, spr_gnt, spr_vld, ri_gnt, ri_vld,
        input  rd_d, vram_a, vram_d, vram_wr, pal_d
    );

    modport slave (
        input  bg_req, bg_a, spr_req, spr_a,
        input  ri_req, ri_wr, ri_a, ri_d,
        input  vram_q, pal_idx,
        output bg_gnt, bg_vld, spr_gnt, spr_vld, ri_gnt, ri_vld,
        output rd_d, vram_a, vram_d, vram_wr, pal_d
    );
endinterface

// File: rtl/ppu_vram_arb.sv
// VRAM bus arbiter (bg > spr > ri with ri anti-starvation promotion) that
// also owns the 32x6 palette RAM mapped at $3F00-$3FFF.
module ppu_vram_arb #(
    parameter int unsigned STARVE_LIM = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    ppu_vram_arb_if.slave    bus
);
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;
    localparam int unsigned PW = 6;
    localparam int unsigned IW = 5;
    localparam int unsigned CW = 4;
    localparam int unsigned PN = 32;

    typedef enum logic [1:0] {
        OWN_BG  = 2'd0,
        OWN_SPR = 2'd1,
        OWN_RI  = 2'd2
    } own_e;

    typedef struct packed {
        logic          vld;
        own_e          own;
        logic          pal;
        logic [IW-1:0] idx;
    } tag_t;

    // $3F10/14/18/1C alias the backdrop entries $3F00/04/08/0C
    function automatic logic [IW-1:0] pal_mirror(input logic [IW-1:0] i);
        return {i[4] & (i[1:0] != 2'b00), i[3:0]};
    endfunction

    function automatic logic is_pal(input logic [AW-1:0] a);
        return a[13:8] == 6'h3F;
    endfunction

    logic [PW-1:0] pal_ram [PN];

    logic [CW-1:0] starve;
    logic [CW-1:0] starve_nxt;
    logic          pw_en;
    tag_t          s1;
    tag_t          s2;

    logic          bg_el;
    logic          spr_el;
    logic          ri_el;
    logic          promote;
    logic          win_bg;
    logic          win_spr;
    logic          win_ri;
    logic [AW-1:0] win_a;
    tag_t          win_tag;

    // arbitration, starvation counter update and read-tag generation
    always_comb begin
        bg_el      = bus.bg_req  & ~bus.bg_gnt;
        spr_el     = bus.spr_req & ~bus.spr_gnt;
        ri_el      = bus.ri_req  & ~bus.ri_gnt;
        promote    = ri_el && (starve >= CW'(STARVE_LIM));
        win_bg     = 1'b0;
        win_spr    = 1'b0;
        win_ri     = 1'b0;
        win_a      = bus.bg_a;
        win_tag    = '0;
        starve_nxt = starve;

        if (promote) begin
            win_ri = 1'b1;
        end else if (bg_el) begin
            win_bg = 1'b1;
        end else if (spr_el) begin
            win_spr = 1'b1;
        end else if (ri_el) begin
            win_ri = 1'b1;
        end

        if (win_spr) begin
            win_a = bus.spr_a;
        end else if (win_ri) begin
            win_a = bus.ri_a;
        end

        if (!bus.ri_req || win_ri) begin
            starve_nxt = '0;
        end else if (ri_el && (starve != '1)) begin
            starve_nxt = starve + CW'(1);
        end

        win_tag.vld = win_bg | win_spr | (win_ri & ~bus.ri_wr);
        win_tag.own = win_spr ? OWN_SPR : (win_ri ? OWN_RI : OWN_BG);
        win_tag.pal = is_pal(win_a);
        win_tag.idx = pal_mirror(win_a[IW-1:0]);
    end

    // grant/bus registers, read tag pipeline and read return
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bg_gnt  <= 1'b0;
            bus.spr_gnt <= 1'b0;
            bus.ri_gnt  <= 1'b0;
            bus.bg_vld  <= 1'b0;
            bus.spr_vld <= 1'b0;
            bus.ri_vld  <= 1'b0;
            bus.rd_d    <= '0;
            bus.vram_a  <= '0;
            bus.vram_d  <= '0;
            bus.vram_wr <= 1'b0;
            bus.pal_d   <= '0;
            pw_en       <= 1'b0;
            starve      <= '0;
            s1          <= '0;
            s2          <= '0;
        end else begin
            bus.bg_gnt  <= win_bg;
            bus.spr_gnt <= win_spr;
            bus.ri_gnt  <= win_ri;
            if (win_bg | win_spr | win_ri) begin
                bus.vram_a <= win_a;
            end
            if (win_ri & bus.ri_wr) begin
                bus.vram_d <= bus.ri_d;
            end
            bus.vram_wr <= win_ri & bus.ri_wr & ~is_pal(bus.ri_a);
            pw_en       <= win_ri & bus.ri_wr &  is_pal(bus.ri_a);
            starve      <= starve_nxt;

            s1 <= win_tag;
            s2 <= s1;
            bus.bg_vld  <= s2.vld && (s2.own == OWN_BG);
            bus.spr_vld <= s2.vld && (s2.own == OWN_SPR);
            bus.ri_vld  <= s2.vld && (s2.own == OWN_RI);
            if (s2.vld) begin
                bus.rd_d <= s2.pal ? {2'b00, pal_ram[s2.idx]} : bus.vram_q;
            end

            bus.pal_d <= pal_ram[pal_mirror(bus.pal_idx)];
        end
    end

    // palette commit one cycle after the write grant, reusing the bus address/data regs
    always_ff @(posedge clk) begin
        if (pw_en) begin
            pal_ram[pal_mirror(bus.vram_a[IW-1:0])] <= bus.vram_d[PW-1:0];
        end
    end

endmodule

// File: tb/tb_ppu_vram_arb.sv
// Directed vector bench for ppu_vram_arb: per-cycle stimulus/expectation
// table plus hand sequences for reset corner cases.
module tb_ppu_vram_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_vec = 0;
    int   n_fail = 0;

    ppu_vram_arb_if bus ();

    ppu_vram_arb #(.STARVE_LIM(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // memory returns data the cycle after the address is presented
    function automatic logic [7:0] mem_f(input logic [13:0] a);
        return (a == 14'h2000) ? 8'h5A : (a[7:0] ^ 8'hC3);
    endfunction

    always @(posedge clk) bus.vram_q <= mem_f(bus.vram_a);

    typedef struct {
        logic [2:0]  req;
        logic [13:0] bg_a;
        logic [13:0] spr_a;
        logic [13:0] ri_a;
        logic        ri_wr;
        logic [7:0]  ri_d;
        logic [4:0]  pidx;
        logic        cp;
        logic [5:0]  pd;
        logic [2:0]  gnt;
        logic [2:0]  vld;
        logic [13:0] va;
        logic        wr;
        logic [7:0]  vd;
        logic [7:0]  rd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic [2:0] req, input logic [13:0] bg_a, input logic [13:0] spr_a,
        input logic [13:0] ri_a, input logic ri_wr, input logic [7:0] ri_d,
        input logic [4:0] pidx, input logic cp, input logic [5:0] pd,
        input logic [2:0] gnt, input logic [2:0] vld, input logic [13:0] va,
        input logic wr, input logic [7:0] vd, input logic [7:0] rd);
        vec_t v;
        v.req = req; v.bg_a = bg_a; v.spr_a = spr_a; v.ri_a = ri_a;
        v.ri_wr = ri_wr; v.ri_d = ri_d; v.pidx = pidx; v.cp = cp; v.pd = pd;
        v.gnt = gnt; v.vld = vld; v.va = va; v.wr = wr; v.vd = vd; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [13:0] act, input logic [13:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string nm, input logic with_pal);
        chk({nm, " gnt"},  14'({bus.ri_gnt, bus.spr_gnt, bus.bg_gnt}), 14'h0);
        chk({nm, " vld"},  14'({bus.ri_vld, bus.spr_vld, bus.bg_vld}), 14'h0);
        chk({nm, " va"},   bus.vram_a, 14'h0);
        chk({nm, " wr"},   14'(bus.vram_wr), 14'h0);
        chk({nm, " vd"},   14'(bus.vram_d), 14'h0);
        chk({nm, " rd"},   14'(bus.rd_d), 14'h0);
        if (with_pal) chk({nm, " pal"}, 14'(bus.pal_d), 14'h0);
    endtask

    task automatic idle_inputs();
        bus.bg_req = 1'b0;  bus.bg_a = '0;
        bus.spr_req = 1'b0; bus.spr_a = '0;
        bus.ri_req = 1'b0;  bus.ri_wr = 1'b0; bus.ri_a = '0; bus.ri_d = '0;
        bus.pal_idx = '0;
    endtask

    initial begin
        idle_inputs();
        bus.vram_q = '0;

        // req            bg_a      spr_a     ri_a      wr  d      pidx   cp pd     gnt     vld     va        wr vd     rd
        vt.push_back(mk(3'b001, 14'h2000, 14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b001, 3'b000, 14'h2000, 0, 8'h00, 8'h00));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b000, 14'h2000, 0, 8'h00, 8'h00));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b001, 14'h2000, 0, 8'h00, 8'h5A));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b000, 14'h2000, 0, 8'h00, 8'h5A));
        vt.push_back(mk(3'b111, 14'h0100, 14'h1055, 14'h2123, 0, 8'h00, 5'h00, 0, 6'h00, 3'b001, 3'b000, 14'h0100, 0, 8'h00, 8'h5A));
        vt.push_back(mk(3'b111, 14'h0100, 14'h1055, 14'h2123, 0, 8'h00, 5'h00, 0, 6'h00, 3'b010, 3'b000, 14'h1055, 0, 8'h00, 8'h5A));
        vt.push_back(mk(3'b111, 14'h0100, 14'h1055, 14'h2123, 0, 8'h00, 5'h00, 0, 6'h00, 3'b001, 3'b001, 14'h0100, 0, 8'h00, 8'hC3));
        vt.push_back(mk(3'b111, 14'h0100, 14'h1055, 14'h2123, 0, 8'h00, 5'h00, 0, 6'h00, 3'b010, 3'b010, 14'h1055, 0, 8'h00, 8'h96));
        vt.push_back(mk(3'b111, 14'h0100, 14'h1055, 14'h2123, 0, 8'h00, 5'h00, 0, 6'h00, 3'b100, 3'b001, 14'h2123, 0, 8'h00, 8'hC3));
        vt.push_back(mk(3'b011, 14'h0100, 14'h1055, 14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b001, 3'b010, 14'h0100, 0, 8'h00, 8'h96));
        vt.push_back(mk(3'b010, 14'h0,    14'h1055, 14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b010, 3'b100, 14'h1055, 0, 8'h00, 8'hE0));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b001, 14'h1055, 0, 8'h00, 8'hC3));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b010, 14'h1055, 0, 8'h00, 8'h96));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b000, 14'h1055, 0, 8'h00, 8'h96));
        vt.push_back(mk(3'b100, 14'h0,    14'h0,    14'h3F10, 1, 8'h2C, 5'h00, 0, 6'h00, 3'b100, 3'b000, 14'h3F10, 0, 8'h2C, 8'h96));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b000, 14'h3F10, 0, 8'h2C, 8'h96));
        vt.push_back(mk(3'b100, 14'h0,    14'h0,    14'h3F00, 0, 8'h00, 5'h00, 1, 6'h2C, 3'b100, 3'b000, 14'h3F00, 0, 8'h2C, 8'h96));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h10, 1, 6'h2C, 3'b000, 3'b000, 14'h3F00, 0, 8'h2C, 8'h96));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b100, 14'h3F00, 0, 8'h2C, 8'h2C));
        vt.push_back(mk(3'b100, 14'h0,    14'h0,    14'h2400, 1, 8'hA5, 5'h00, 0, 6'h00, 3'b100, 3'b000, 14'h2400, 1, 8'hA5, 8'h2C));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b000, 14'h2400, 0, 8'hA5, 8'h2C));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b000, 14'h2400, 0, 8'hA5, 8'h2C));
        vt.push_back(mk(3'b001, 14'h3F10, 14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b001, 3'b000, 14'h3F10, 0, 8'hA5, 8'h2C));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b000, 14'h3F10, 0, 8'hA5, 8'h2C));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b001, 14'h3F10, 0, 8'hA5, 8'h2C));
        vt.push_back(mk(3'b100, 14'h0,    14'h0,    14'h3F14, 1, 8'h7F, 5'h00, 0, 6'h00, 3'b100, 3'b000, 14'h3F14, 0, 8'h7F, 8'h2C));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h14, 0, 6'h00, 3'b000, 3'b000, 14'h3F14, 0, 8'h7F, 8'h2C));
        vt.push_back(mk(3'b100, 14'h0,    14'h0,    14'h3F14, 0, 8'h00, 5'h04, 1, 6'h3F, 3'b100, 3'b000, 14'h3F14, 0, 8'h7F, 8'h2C));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h14, 1, 6'h3F, 3'b000, 3'b000, 14'h3F14, 0, 8'h7F, 8'h2C));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 0, 6'h00, 3'b000, 3'b100, 14'h3F14, 0, 8'h7F, 8'h3F));
        vt.push_back(mk(3'b100, 14'h0,    14'h0,    14'h3F00, 1, 8'h11, 5'h00, 0, 6'h00, 3'b100, 3'b000, 14'h3F00, 0, 8'h11, 8'h3F));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 1, 6'h2C, 3'b000, 3'b000, 14'h3F00, 0, 8'h11, 8'h3F));
        vt.push_back(mk(3'b000, 14'h0,    14'h0,    14'h0,    0, 8'h00, 5'h00, 1, 6'h11, 3'b000, 3'b000, 14'h3F00, 0, 8'h11, 8'h3F));

        // reset: outputs held at zero, then no grant with all requests low
        #1 rst_n = 1'b0;
        #1 chk_zero("rst_async", 1'b1);
        repeat (2) @(posedge clk);
        #1 chk_zero("rst_hold", 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk_zero("rst_release", 1'b0);

        foreach (vt[i]) begin
            @(negedge clk);
            bus.bg_req  = vt[i].req[0]; bus.bg_a  = vt[i].bg_a;
            bus.spr_req = vt[i].req[1]; bus.spr_a = vt[i].spr_a;
            bus.ri_req  = vt[i].req[2]; bus.ri_a  = vt[i].ri_a;
            bus.ri_wr   = vt[i].ri_wr;  bus.ri_d  = vt[i].ri_d;
            bus.pal_idx = vt[i].pidx;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d gnt", i), 14'({bus.ri_gnt, bus.spr_gnt, bus.bg_gnt}), 14'(vt[i].gnt));
            chk($sformatf("v%0d vld", i), 14'({bus.ri_vld, bus.spr_vld, bus.bg_vld}), 14'(vt[i].vld));
            chk($sformatf("v%0d vram_a", i), bus.vram_a, vt[i].va);
            chk($sformatf("v%0d vram_wr", i), 14'(bus.vram_wr), 14'(vt[i].wr));
            chk($sformatf("v%0d vram_d", i), 14'(bus.vram_d), 14'(vt[i].vd));
            chk($sformatf("v%0d rd_d", i), 14'(bus.rd_d), 14'(vt[i].rd));
            if (vt[i].cp) chk($sformatf("v%0d pal_d", i), 14'(bus.pal_d), 14'(vt[i].pd));
        end

        // palette write granted, reset before commit: entry 0 keeps 0x11
        @(negedge clk);
        idle_inputs();
        bus.ri_req = 1'b1; bus.ri_wr = 1'b1; bus.ri_a = 14'h3F00; bus.ri_d = 8'h22;
        @(posedge clk);
        #1 chk("drop gnt", 14'(bus.ri_gnt), 14'h1);
        #1 rst_n = 1'b0;
        idle_inputs();
        #1 chk_zero("drop rst", 1'b1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 chk("drop pal0", 14'(bus.pal_d), 14'h11);
        @(posedge clk);
        #1 chk("drop pal1", 14'(bus.pal_d), 14'h11);

        // spr read granted, reset in the data-return window: no spr_vld ever
        @(negedge clk);
        bus.spr_req = 1'b1; bus.spr_a = 14'h0ABC;
        @(posedge clk);
        #1 chk("sprrst gnt", 14'(bus.spr_gnt), 14'h1);
        @(negedge clk) bus.spr_req = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_zero("sprrst async", 1'b1);
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1 chk($sformatf("sprrst vld%0d", k), 14'({bus.ri_vld, bus.spr_vld, bus.bg_vld}), 14'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/ppu_vram_arb.md
# ppu_vram_arb

VRAM bus arbiter and palette-RAM owner for the PPU. Shares the single 14-bit video memory bus between three requesters: background fetch, sprite fetch, and register-interface (CPU $2007) accesses. It intercepts the palette region $3F00-$3FFF into an internal 32x6 palette RAM. It also provides a dedicated registered palette lookup port for the pixel output path.

## Interface
- STARVE_LIM, 4: consecutive blocked cycles before a pending ri request is promoted to top priority (1-15).
- clk_in  input  1  system clock (50 MHz).
- rst_n_in  input  1  reset; asynchronous, active-low.
- bg_req_in  input  1  background read request.
- bg_a_in  input  14  background read address.
- bg_gnt_out  output  1  one-cycle grant pulse to background.
- bg_vld_out  output  1  background read data valid on rd_d_out.
- spr_req_in / spr_a_in[13:0] / spr_gnt_out / spr_vld_out: same as bg, for sprites.
- ri_req_in  input  1  register-interface request.
- ri_wr_in  input  1  1 = write, 0 = read.
- ri_a_in  input  14  ri address.
- ri_d_in  input  8  ri write data.
- ri_gnt_out / ri_vld_out  output  1  ri grant pulse and read-valid pulse.
- rd_d_out  output  8  shared read-return data.
- vram_a_out  output  14  video memory address.
- vram_d_out  output  8  video memory write data.
- vram_wr_out  output  1  video memory write strobe.
- vram_d_in  input  8  video memory read data, valid the cycle after vram_a_out is presented.
- pal_idx_in  input  5  pixel-path palette index.
- pal_d_out  output  6  pixel-path palette entry.

## Operation
- Requesters hold req, address and data stable until they see their gnt pulse. They may drop or change req in the gnt cycle.
- Arbitration runs each cycle over eligible requests. A requester whose gnt_out is currently high is masked, so each requester gets at most one grant every 2 cycles.
- Default priority is bg > spr > ri.
- Starvation counter (4 bits):
  - Increments each cycle ri_req_in is eligible but not granted.
  - When it reaches STARVE_LIM, ri takes top priority for the next arbitration.
  - Clears on ri grant and when ri_req_in is low.
- On a grant in cycle N, the following are registered and appear in cycle N+1:
  - the winner's gnt_out pulse;
  - vram_a_out = winner address;
  - vram_d_out = ri_d_in for ri writes; otherwise it holds its previous value.
- Palette region: address[13:8] == 6'h3F.
  - Palette index = a[4:0], with bit 4 forced to 0 when a[1:0] == 0, so $3F10/14/18/1C mirror $3F00/04/08/0C.
- ri write outside the palette region: vram_wr_out = 1 for cycle N+1 only.
- ri write inside the palette region: vram_wr_out stays 0, and palette_ram[idx] <= ri_d_in[5:0] at the end of cycle N+1.
- Reads:
  - A 2-stage tag pipeline (owner, palette flag, palette index) follows each read grant.
  - In cycle N+3, rd_d_out = registered vram_d_in, or {2'b00, palette entry} for palette reads, and the owner's vld_out pulses for exactly 1 cycle.
  - Writes produce no vld.
- Pixel port: pal_d_out <= palette_ram[mirror(pal_idx_in)] every cycle.
  - A same-cycle write returns the old entry.
- Idle cycles: vram_a_out holds its last value; vram_wr_out = 0.
- Palette RAM contents are not reset.

## Timing
- Reset (rst_n_in low, asynchronous):
  - all gnt/vld outputs, vram_wr_out, vram_a_out, vram_d_out, rd_d_out and pal_d_out go to 0;
  - starvation counter and tag pipeline clear;
  - in-flight reads never produce vld;
  - a write granted but not yet committed is dropped.
- Grant latency: 1 cycle from req sampling to gnt. Read data latency: 3 cycles from sampling (2 after gnt).
- Back-to-back grants to alternating requesters are allowed every cycle; full bus throughput = 1 access/cycle.
- Simultaneous vld pulses cannot occur; at most one vld per cycle.
- Promoted ri beats bg and spr for one arbitration only, then the counter clears.

## Test plan
- Reset → all outputs 0 during and 1 cycle after release; no gnt while all reqs are low.
- bg_req_in with bg_a_in = 0x2000 sampled in cycle N, memory returns 0x5A → bg_gnt_out in N+1 with vram_a_out = 0x2000; bg_vld_out and rd_d_out = 0x5A in N+3.
- bg, spr and ri held continuously with STARVE_LIM = 4 → grant sequence bg, spr, bg, spr, then ri on the 5th arbitration, then bg resumes.
- ri write 0x3F10 with data 0x2C → vram_wr_out stays 0; pal_idx_in = 0x00 → pal_d_out = 0x2C next cycle; ri read 0x3F00 → rd_d_out = 0x2C with ri_vld_out.
- ri write 0x2400 with data 0xA5 → exactly one cycle of vram_wr_out = 1 with vram_a_out = 0x2400 and vram_d_out = 0xA5; no ri_vld_out.
- spr read granted, then rst_n_in pulsed low in N+2 → spr_vld_out never asserts; all outputs 0 immediately (asynchronous).
